// File: rtl/itoa_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | itoa_pkg : state encodings and ASCII constants for the number/text path.    |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
package itoa_pkg;

    typedef enum logic [2:0] {
        INI = 3'd0,
        SGN = 3'd1,
        DIV = 3'd2,
        EMT = 3'd3,
        NEG = 3'd4,
        RET = 3'd5
    } itoa_sts;

    typedef enum logic [2:0] {
        ATOI_INI = 3'd0,
        ATOI_SGN = 3'd1,
        ATOI_DIG = 3'd2,
        ATOI_ERR = 3'd3,
        ATOI_RET = 3'd4
    } atoi_sts;

    localparam logic [7:0] c_ASC_ZERO  = 8'h30;
    localparam logic [7:0] c_ASC_UPA   = 8'h41;
    localparam logic [7:0] c_ASC_MINUS = 8'h2D;

    // Digit value 0..15 to uppercase ASCII.
    function automatic logic [7:0] digit_char(input logic [3:0] d);
        if (d < 4'd10)
            return c_ASC_ZERO + {4'd0, d};
        else
            return c_ASC_UPA + {4'd0, d} - 8'd10;
    endfunction

endpackage
`default_nettype wire

// File: rtl/itoa_div10.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | div10 : serial restoring unsigned divide-by-10, one quotient bit per cycle. |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module div10 #(
    parameter int DSZ = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [DSZ-1:0] dividend,
    output logic [DSZ-1:0] q,
    output logic [3:0]     r,
    output logic           done
);

    localparam int CW = $clog2(DSZ);

    logic [DSZ-1:0] r_sh;
    logic [3:0]     r_rem;
    logic [CW-1:0]  r_cnt;
    logic           r_act;

    logic [DSZ-1:0] w_sh_in;
    logic [DSZ-1:0] w_sh_nxt;
    logic [3:0]     w_rem_in;
    logic [3:0]     w_rem_nxt;
    logic [4:0]     w_t;
    logic           w_ge;

    // The start cycle already performs the first iteration on the raw dividend,
    // so the whole divide occupies exactly DSZ cycles.
    always_comb begin
        w_sh_in   = start ? dividend : r_sh;
        w_rem_in  = start ? 4'd0 : r_rem;
        w_t       = {w_rem_in, w_sh_in[DSZ-1]};
        w_ge      = (w_t >= 5'd10);
        w_rem_nxt = w_ge ? 4'(w_t - 5'd10) : w_t[3:0];
        w_sh_nxt  = {w_sh_in[DSZ-2:0], w_ge};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh  <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            r_act <= 1'b0;
        end else begin
            if (start) begin
                r_act <= 1'b1;
                r_cnt <= CW'(1);
            end else if (r_act) begin
                r_cnt <= r_cnt + CW'(1);
                if (done)
                    r_act <= 1'b0;
            end
            if (start || r_act) begin
                r_sh  <= w_sh_nxt;
                r_rem <= w_rem_nxt;
            end
        end
    end

    assign done = r_act && (r_cnt == CW'(DSZ - 1));
    assign q    = r_sh;
    assign r    = r_rem;

endmodule
`default_nettype wire

// File: rtl/itoa.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | itoa : binary to ASCII converter, least-significant digit first, then '-'.  |
// |        Define ITOA_UDOT_EN to add the 'uns' input (unsigned decimal).       |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module itoa #(
    parameter int DSZ = 32,
    parameter int LSZ = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           hex,
`ifdef ITOA_UDOT_EN
    input  logic           uns,
`endif
    input  logic [DSZ-1:0] vi,
    output logic [2:0]     st,
    output logic           bsy,
    output logic           we,
    output logic           ao,
    output logic [7:0]     co,
    output logic [LSZ-1:0] len
);

    import itoa_pkg::*;

    itoa_sts        r_st;
    itoa_sts        w_nxt;
    logic [DSZ-1:0] r_v;
    logic [DSZ-1:0] r_q;
    logic [3:0]     r_r;
    logic           r_hex;
    logic           r_neg;
    logic           r_bsy;
    logic           r_first;
    logic [LSZ-1:0] r_len;
    logic [7:0]     r_co;

    logic [DSZ-1:0] w_dq;
    logic [3:0]     w_dr;
    logic [DSZ-1:0] w_q;
    logic [3:0]     w_r;
    logic           w_done;
    logic           w_start;
    logic           w_neg;
    logic           w_we;
    logic [7:0]     w_co;

`ifdef ITOA_UDOT_EN
    logic           r_uns;
    assign w_neg = ~r_hex & ~r_uns & r_v[DSZ-1];
`else
    assign w_neg = ~r_hex & r_v[DSZ-1];
`endif

    assign w_start = (r_st == DIV) && r_first && !r_hex;

    div10 #(
        .DSZ      (DSZ)
    ) u_div10 (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .dividend (r_v),
        .q        (w_dq),
        .r        (w_dr),
        .done     (w_done)
    );

    // Hex bypasses the divider with a single nibble shift.
    assign w_q = r_hex ? r_q : w_dq;
    assign w_r = r_hex ? r_r : w_dr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_st <= INI;
        else
            r_st <= w_nxt;
    end

    always_comb begin
        w_nxt = r_st;
        w_we  = 1'b0;
        w_co  = r_co;
        case (r_st)
            INI: if (en) w_nxt = SGN;
            SGN: w_nxt = DIV;
            DIV: if (r_hex || w_done) w_nxt = EMT;
            EMT: begin
                w_we = 1'b1;
                w_co = digit_char(w_r);
                if (w_q != '0)
                    w_nxt = DIV;
                else if (r_neg)
                    w_nxt = NEG;
                else
                    w_nxt = RET;
            end
            NEG: begin
                w_we  = 1'b1;
                w_co  = c_ASC_MINUS;
                w_nxt = RET;
            end
            RET:     w_nxt = INI;
            default: w_nxt = INI;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v     <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_hex   <= 1'b0;
            r_neg   <= 1'b0;
            r_bsy   <= 1'b0;
            r_first <= 1'b0;
            r_len   <= '0;
            r_co    <= '0;
`ifdef ITOA_UDOT_EN
            r_uns   <= 1'b0;
`endif
        end else begin
            case (r_st)
                INI: if (en) begin
                    r_v   <= vi;
                    r_hex <= hex;
                    r_bsy <= 1'b1;
`ifdef ITOA_UDOT_EN
                    r_uns <= uns;
`endif
                end
                SGN: begin
                    r_neg   <= w_neg;
                    r_v     <= w_neg ? -r_v : r_v;
                    r_len   <= '0;
                    r_first <= 1'b1;
                end
                DIV: begin
                    r_first <= 1'b0;
                    if (r_hex) begin
                        r_q <= r_v >> 4;
                        r_r <= r_v[3:0];
                    end
                end
                EMT: begin
                    r_len   <= r_len + LSZ'(1);
                    r_v     <= w_q;
                    r_first <= 1'b1;
                    r_co    <= w_co;
                end
                NEG: begin
                    r_len <= r_len + LSZ'(1);
                    r_co  <= w_co;
                end
                RET:     r_bsy <= 1'b0;
                default: ;
            endcase
        end
    end

    assign st  = r_st;
    assign bsy = r_bsy;
    assign we  = w_we;
    assign ao  = w_we;
    assign co  = w_co;
    assign len = r_len;

endmodule
`default_nettype wire

// File: tb/tb_itoa.sv
`default_nettype none
// Testbench for itoa: reference model of the emitted character stream and timing.
module tb_itoa;

    localparam int DSZ = 32;
    localparam int LSZ = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           en  = 1'b0;
    logic           hex = 1'b0;
    logic [DSZ-1:0] vi  = '0;
`ifdef ITOA_UDOT_EN
    logic           uns = 1'b0;
`endif
    logic [2:0]     st;
    logic           bsy;
    logic           we;
    logic           ao;
    logic [7:0]     co;
    logic [LSZ-1:0] len;

    int  checks = 0;
    int  errors = 0;
    byte m_q[$];
    byte exp_q[$];
    int  gap = DSZ + 1;
    int  cyc = 0;
    int  last_cyc = 0;
    int  strobe_idx = 0;
    int  bsy_cnt = 0;

    always #5 clk = ~clk;

    itoa #(
        .DSZ (DSZ),
        .LSZ (LSZ)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .hex (hex),
`ifdef ITOA_UDOT_EN
        .uns (uns),
`endif
        .vi  (vi),
        .st  (st),
        .bsy (bsy),
        .we  (we),
        .ao  (ao),
        .co  (co),
        .len (len)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Expected character stream from plain base-10/16 arithmetic.
    function automatic void model(input logic [DSZ-1:0] val, input bit hx, input bit un);
        longint unsigned mag;
        longint unsigned base;
        int d;
        bit ng;
        m_q.delete();
        base = hx ? 64'd16 : 64'd10;
        ng   = !hx && !un && val[DSZ-1];
        mag  = 64'(val);
        if (ng) mag = (64'd1 << DSZ) - mag;
        do begin
            d = int'(mag % base);
            m_q.push_back(d < 10 ? byte'(8'h30 + d) : byte'(8'h41 + d - 10));
            mag = mag / base;
        end while (mag != 0);
        if (ng) m_q.push_back(8'h2D);
    endfunction

    task automatic pin(input string name, input logic [DSZ-1:0] val, input bit hx, input bit un,
                       input string s);
        string got;
        got = "";
        model(val, hx, un);
        foreach (m_q[i]) got = $sformatf("%s%c", got, m_q[i]);
        checks++;
        if (got != s) begin
            errors++;
            $display("FAIL pin_%s actual=%s expected=%s", name, got, s);
        end
    endtask

    task automatic run(input string name, input logic [DSZ-1:0] val, input bit hx, input bit un,
                       input bit hold);
        int n, ng, lat, t;
        model(val, hx, un);
        n  = m_q.size();
        ng = (m_q[n-1] == 8'h2D) ? 1 : 0;
        gap = hx ? 2 : DSZ + 1;
        foreach (m_q[i]) exp_q.push_back(m_q[i]);
        @(negedge clk);
        bsy_cnt    = 0;
        strobe_idx = 0;
        en  = 1'b1;
        hex = hx;
        vi  = val;
`ifdef ITOA_UDOT_EN
        uns = un;
`endif
        @(negedge clk);
        if (!hold) en = 1'b0;
        vi  = $urandom;
        hex = ~hx;
`ifdef ITOA_UDOT_EN
        uns = ~un;
`endif
        t = 0;
        while (bsy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        en = 1'b0;
        chk({name, "_timeout"}, (t >= 3000) ? 1 : 0, 0);
        chk({name, "_len"}, len, n);
        chk({name, "_missing_chars"}, exp_q.size(), 0);
        lat = 2 + (n - ng) * (hx ? 2 : DSZ + 1) + ng + 1;
        chk({name, "_latency"}, bsy_cnt + 1, lat);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        byte c;
        cyc++;
        if (rst) begin
            if (bsy) bsy_cnt++;
            if (we || ao) chk("ao_eq_we", ao, we);
            if (we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", co, 0);
                end else begin
                    c = exp_q.pop_front();
                    chk("char", co, c);
                    if (strobe_idx > 0) chk("strobe_gap", cyc - last_cyc, (c == 8'h2D) ? 1 : gap);
                    last_cyc = cyc;
                    strobe_idx++;
                end
            end
        end
    end

    initial begin
        int t;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_st", st, 0);
        chk("rst_bsy", bsy, 0);
        chk("rst_we", we, 0);
        chk("rst_ao", ao, 0);
        chk("rst_co", co, 0);
        chk("rst_len", len, 0);
        rst = 1'b1;

        pin("1234", 32'd1234, 0, 0, "4321");
        pin("m305", 32'hFFFFFECF, 0, 0, "503-");
        pin("deadbeef", 32'hDEADBEEF, 1, 0, "FEEBDAED");
        pin("zero", 32'd0, 0, 0, "0");
        pin("min", 32'h80000000, 0, 0, "8463847412-");
        pin("umax", 32'hFFFFFFFF, 0, 1, "5927694924");
        pin("m1", 32'hFFFFFFFF, 0, 0, "1-");

        run("dec1234", 32'd1234, 0, 0, 0);
        run("dec_m305", 32'hFFFFFECF, 0, 0, 0);
        run("hex_deadbeef", 32'hDEADBEEF, 1, 0, 0);
        run("dec_zero", 32'd0, 0, 0, 0);
        run("hex_zero", 32'd0, 1, 0, 0);
        run("dec_min", 32'h80000000, 0, 0, 0);

        // Abort mid-conversion with the asynchronous reset.
        model(32'd98765, 0, 0);
        foreach (m_q[i]) exp_q.push_back(m_q[i]);
        gap = DSZ + 1;
        @(negedge clk);
        bsy_cnt = 0;
        strobe_idx = 0;
        en  = 1'b1;
        hex = 1'b0;
        vi  = 32'd98765;
        @(negedge clk);
        en = 1'b0;
        t = 0;
        while (strobe_idx < 1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("abort_timeout", (t >= 200) ? 1 : 0, 0);
        repeat (10) @(negedge clk);
        chk("abort_len_before", len, 1);
        chk("abort_bsy_before", bsy, 1);
        #2 rst = 1'b0;
        #1;
        chk("abort_we", we, 0);
        chk("abort_bsy", bsy, 0);
        chk("abort_len", len, 0);
        chk("abort_st", st, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_quiet_bsy", bsy, 0);

        run("after_rst7", 32'd7, 0, 0, 0);
        run("hold_en", 32'd90210, 0, 0, 1);
        run("hex_hold_en", 32'h0000A5C3, 1, 0, 1);
`ifdef ITOA_UDOT_EN
        run("udot_max", 32'hFFFFFFFF, 0, 1, 0);
        run("dot_m1", 32'hFFFFFFFF, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
